// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings for the MEM-stage memory access unit.
package mem_pkg;
    typedef enum logic [2:0] {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW} mem_op_e;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} mem_size_e;
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} mem_state_e;
endpackage

// File: rtl/mem_align.sv
// mem_align: load extraction, store lane replication and misalignment detection.
module mem_align
    import mem_pkg::*;
(
    input  mem_op_e     i_op,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_wdata,
    input  mem_op_e     i_ld_op,
    input  logic [1:0]  i_ld_lane,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_ld_data,
    output logic [31:0] o_st_data,
    output mem_size_e   o_size,
    output logic        o_store,
    output logic        o_misalign
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    assign w_byte = i_rdata[{i_ld_lane, 3'b000} +: 8];
    assign w_half = i_ld_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
    always_comb begin
        o_ld_data = i_rdata;
        case (i_ld_op)
            OP_LB:   o_ld_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_ld_data = {24'b0, w_byte};
            OP_LH:   o_ld_data = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_ld_data = {16'b0, w_half};
            default: o_ld_data = i_rdata;
        endcase
    end
    always_comb begin
        o_size    = SZ_WORD;
        o_st_data = i_wdata;
        case (i_op)
            OP_LB, OP_LBU: o_size = SZ_BYTE;
            OP_LH, OP_LHU: o_size = SZ_HALF;
            OP_SB: begin
                o_size    = SZ_BYTE;
                o_st_data = {4{i_wdata[7:0]}};
            end
            OP_SH: begin
                o_size    = SZ_HALF;
                o_st_data = {2{i_wdata[15:0]}};
            end
            default: o_size = SZ_WORD;
        endcase
    end
    assign o_store    = i_op inside {OP_SB, OP_SH, OP_SW};
    assign o_misalign = (o_size == SZ_HALF && i_lane[0]) || (o_size == SZ_WORD && i_lane != 2'b00);
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit driving a req/addr_ok/data_ok bus.
// Holds the pipeline while an access is in flight; flushes discard late data.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en_i,
    input  logic [2:0]  mem_op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        flush_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        adel_o,
    output logic        ades_o,
    output logic [31:0] badvaddr_o,
    output logic        bus_err_o,
    output logic        data_req_o,
    output logic        data_wr_o,
    output logic [1:0]  data_size_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_addr_ok_i,
    input  logic        data_data_ok_i,
    input  logic [31:0] data_rdata_i
);
    localparam int CW = $clog2(BUS_TIMEOUT + 1);
    mem_state_e    r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic          r_discard, r_bus_err, r_wr;
    mem_op_e       r_op;
    mem_size_e     r_size, w_size;
    logic [31:0]   r_addr, r_wdata, r_rdata, w_ld_data, w_st_data;
    logic          w_store, w_misalign, w_start, w_timeout, w_finish;
    mem_align u_align (
        .i_op       (mem_op_e'(mem_op_i)),
        .i_lane     (addr_i[1:0]),
        .i_wdata    (wdata_i),
        .i_ld_op    (r_op),
        .i_ld_lane  (r_addr[1:0]),
        .i_rdata    (data_rdata_i),
        .o_ld_data  (w_ld_data),
        .o_st_data  (w_st_data),
        .o_size     (w_size),
        .o_store    (w_store),
        .o_misalign (w_misalign)
    );
    assign w_start   = mem_en_i && !w_misalign && !flush_i;
    assign w_timeout = r_cnt == CW'(BUS_TIMEOUT - 1);
    assign w_finish  = data_data_ok_i || w_timeout;
    always_comb begin
        w_next     = r_state;
        data_req_o = 1'b0;
        stall_o    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next  = w_start ? S_ADDR : S_IDLE;
                stall_o = mem_en_i && !w_misalign;
            end
            S_ADDR: begin
                w_next     = data_addr_ok_i ? S_DATA : (flush_i ? S_IDLE : S_ADDR);
                data_req_o = 1'b1;
                stall_o    = 1'b1;
            end
            S_DATA: begin
                w_next  = w_finish ? ((r_discard || flush_i) ? S_IDLE : S_DONE) : S_DATA;
                stall_o = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
        stall_o = stall_o && rst;
    end
    // A flush that lands once the bus has accepted the address must still drain data_ok.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_discard <= 1'b0;
            r_bus_err <= 1'b0;
            r_wr      <= 1'b0;
            r_op      <= OP_LB;
            r_size    <= SZ_BYTE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= (r_state == S_DATA) ? r_cnt + 1'b1 : '0;
            r_discard <= (r_state == S_ADDR && data_addr_ok_i && flush_i) ||
                         (r_state == S_DATA && w_next == S_DATA && (r_discard || flush_i));
            r_bus_err <= r_state == S_DATA && w_next == S_DONE && !data_data_ok_i;
            if (r_state == S_IDLE && w_start) begin
                r_wr    <= w_store;
                r_op    <= mem_op_e'(mem_op_i);
                r_size  <= w_size;
                r_addr  <= addr_i;
                r_wdata <= w_st_data;
            end
            if (r_state == S_DATA && w_next == S_DONE)
                r_rdata <= data_data_ok_i ? w_ld_data : '0;
        end
    end
    assign rdata_o      = r_rdata;
    assign bus_err_o    = r_bus_err;
    assign data_wr_o    = r_wr;
    assign data_size_o  = r_size;
    assign data_addr_o  = r_addr;
    assign data_wdata_o = r_wdata;
    assign adel_o       = mem_en_i && w_misalign && !w_store;
    assign ades_o       = mem_en_i && w_misalign && w_store;
    assign badvaddr_o   = addr_i;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of mem_access_unit, plus a short-timeout instance.
module tb_mem_access_unit;
    logic        clk = 1'b0, rst = 1'b0, mem_en = 1'b0, flush = 1'b0, addr_ok = 1'b0, data_ok = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] addr = '0, wdata = '0, bus_rdata = '0;
    logic [31:0] rdata, badv, d_addr, d_wdata, t_rdata, t_badv, t_daddr, t_wdata;
    logic        stall, adel, ades, berr, req, wr, t_stall, t_adel, t_ades, t_berr, t_req, t_wr;
    logic [1:0]  size, t_size;
    int          n_checks = 0, n_fail = 0, stall_cnt, t_cnt;
    logic [31:0] cap_wdata, cap_addr;
    logic [1:0]  cap_size;
    logic        cap_wr, req_seen, seen;
    always #5 clk = ~clk;
    mem_access_unit u_dut (
        .clk(clk), .rst(rst), .mem_en_i(mem_en), .mem_op_i(op), .addr_i(addr), .wdata_i(wdata),
        .flush_i(flush), .rdata_o(rdata), .stall_o(stall), .adel_o(adel), .ades_o(ades),
        .badvaddr_o(badv), .bus_err_o(berr), .data_req_o(req), .data_wr_o(wr), .data_size_o(size),
        .data_addr_o(d_addr), .data_wdata_o(d_wdata), .data_addr_ok_i(addr_ok),
        .data_data_ok_i(data_ok), .data_rdata_i(bus_rdata)
    );
    mem_access_unit #(.BUS_TIMEOUT(4)) u_dut_t (
        .clk(clk), .rst(rst), .mem_en_i(mem_en), .mem_op_i(op), .addr_i(addr), .wdata_i(wdata),
        .flush_i(flush), .rdata_o(t_rdata), .stall_o(t_stall), .adel_o(t_adel), .ades_o(t_ades),
        .badvaddr_o(t_badv), .bus_err_o(t_berr), .data_req_o(t_req), .data_wr_o(t_wr), .data_size_o(t_size),
        .data_addr_o(t_daddr), .data_wdata_o(t_wdata), .data_addr_ok_i(addr_ok),
        .data_data_ok_i(data_ok), .data_rdata_i(bus_rdata)
    );
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask
    // One access with addr_ok after a_dly request cycles and data_ok after d_dly data cycles;
    // returns sampled in the DONE cycle.
    task automatic run_access(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input int a_dly, input int d_dly);
        bit in_data = 1'b0, nxt, done = 1'b0;
        int aw = 0, dw = 0;
        stall_cnt = 0;
        @(negedge clk);
        mem_en = 1'b1; op = o; addr = a; wdata = wd; bus_rdata = rd;
        for (int c = 0; c < 40 && !done; c++) begin
            addr_ok = 1'b0;
            data_ok = 1'b0;
            if (in_data) begin
                data_ok = (dw == d_dly);
                dw++;
            end
            #1;
            if (!stall) done = 1'b1;
            else begin
                stall_cnt++;
                if (req) begin
                    addr_ok = (aw == a_dly);
                    aw++;
                    cap_wdata = d_wdata; cap_addr = d_addr; cap_size = size; cap_wr = wr;
                end
                nxt = in_data ? !data_ok : addr_ok;
                @(negedge clk);
                in_data = nxt;
            end
        end
        addr_ok = 1'b0; data_ok = 1'b0; mem_en = 1'b0;
        check("access_done", {31'b0, done}, 32'd1);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    initial begin
        repeat (2) @(negedge clk);
        check("rst_stall", {31'b0, stall}, 0);
        check("rst_req", {31'b0, req}, 0);
        check("rst_rdata", rdata, 0);
        check("rst_berr", {31'b0, berr}, 0);
        check("rst_daddr", d_addr, 0);
        check("rst_wr", {31'b0, wr}, 0);
        rst = 1'b1;
        run_access(3'd0, 32'h1003, 0, 32'h80FF0000, 0, 0);
        check("lb_rdata", rdata, 32'hFFFFFF80);
        check("lb_stall", stall_cnt, 3);
        check("lb_size", {30'b0, cap_size}, 0);
        check("lb_wr", {31'b0, cap_wr}, 0);
        check("lb_addr", cap_addr, 32'h1003);
        run_access(3'd1, 32'h1002, 0, 32'h80FF0000, 2, 1);
        check("lbu_rdata", rdata, 32'h000000FF);
        check("lbu_stall", stall_cnt, 6);
        run_access(3'd2, 32'h1002, 0, 32'h80FF0000, 1, 0);
        check("lh_rdata", rdata, 32'hFFFF80FF);
        check("lh_size", {30'b0, cap_size}, 1);
        run_access(3'd3, 32'h1000, 0, 32'h1234ABCD, 0, 2);
        check("lhu_rdata", rdata, 32'h0000ABCD);
        run_access(3'd4, 32'h1004, 0, 32'hDEADBEEF, 0, 0);
        check("lw_rdata", rdata, 32'hDEADBEEF);
        check("lw_size", {30'b0, cap_size}, 2);
        // flush in DATA, data_ok four cycles later
        @(negedge clk); mem_en = 1'b1; op = 3'd4; addr = 32'h1008; bus_rdata = 32'h55555555;
        @(negedge clk); #1 check("fd_req", {31'b0, req}, 1); addr_ok = 1'b1;
        @(negedge clk); addr_ok = 1'b0; flush = 1'b1;
        #1 check("fd_req_drop", {31'b0, req}, 0);
        check("fd_stall", {31'b0, stall}, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); flush = 1'b0; mem_en = 1'b0;
            #1 check("fd_hold", {31'b0, stall}, 1);
        end
        @(negedge clk); data_ok = 1'b1;
        #1 check("fd_hold4", {31'b0, stall}, 1);
        @(negedge clk); data_ok = 1'b0;
        #1 check("fd_idle_stall", {31'b0, stall}, 0);
        check("fd_rdata", rdata, 32'hDEADBEEF);
        check("fd_berr", {31'b0, berr}, 0);
        @(negedge clk);
        #1 check("fd_rdata2", rdata, 32'hDEADBEEF);
        check("fd_req_idle", {31'b0, req}, 0);
        // flush in ADDR before addr_ok
        @(negedge clk); mem_en = 1'b1; op = 3'd4; addr = 32'h100C;
        @(negedge clk); #1 check("fa_req", {31'b0, req}, 1); flush = 1'b1; mem_en = 1'b0;
        @(negedge clk); flush = 1'b0;
        #1 check("fa_req_drop", {31'b0, req}, 0);
        check("fa_stall", {31'b0, stall}, 0);
        // flush wins over a new request in IDLE
        @(negedge clk); mem_en = 1'b1; op = 3'd4; addr = 32'h1010; flush = 1'b1;
        @(negedge clk); flush = 1'b0; mem_en = 1'b0;
        #1 check("fi_req", {31'b0, req}, 0);
        check("fi_stall", {31'b0, stall}, 0);
        run_access(3'd6, 32'h2002, 32'h1234ABCD, 0, 1, 0);
        check("sh_wdata", cap_wdata, 32'hABCDABCD);
        check("sh_size", {30'b0, cap_size}, 1);
        check("sh_wr", {31'b0, cap_wr}, 1);
        check("sh_stall", stall_cnt, 4);
        run_access(3'd5, 32'h2001, 32'h000000A5, 0, 0, 0);
        check("sb_wdata", cap_wdata, 32'hA5A5A5A5);
        check("sb_size", {30'b0, cap_size}, 0);
        run_access(3'd7, 32'h2004, 32'h11223344, 0, 0, 1);
        check("sw_wdata", cap_wdata, 32'h11223344);
        check("sw_size", {30'b0, cap_size}, 2);
        check("sw_addr", cap_addr, 32'h2004);
        // misaligned accesses never reach the bus
        @(negedge clk); mem_en = 1'b1; op = 3'd4; addr = 32'h3001; req_seen = 1'b0;
        #1 check("mis_adel", {31'b0, adel}, 1);
        check("mis_ades", {31'b0, ades}, 0);
        check("mis_badv", badv, 32'h3001);
        check("mis_stall", {31'b0, stall}, 0);
        check("mis_t_adel", {31'b0, t_adel}, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1 req_seen = req_seen | req;
        end
        check("mis_req", {31'b0, req_seen}, 0);
        op = 3'd6; addr = 32'h2003;
        #1 check("mis_sh_ades", {31'b0, ades}, 1);
        check("mis_sh_adel", {31'b0, adel}, 0);
        check("mis_sh_badv", badv, 32'h2003);
        check("mis_sh_stall", {31'b0, stall}, 0);
        mem_en = 1'b0;
        // reset asserted while in ADDR
        @(negedge clk); mem_en = 1'b1; op = 3'd0; addr = 32'h1003;
        @(negedge clk); #1 check("rr_req_pre", {31'b0, req}, 1);
        #2 rst = 1'b0;
        #1 check("rr_req", {31'b0, req}, 0);
        check("rr_stall", {31'b0, stall}, 0);
        check("rr_rdata", rdata, 0);
        @(negedge clk); rst = 1'b1; mem_en = 1'b0;
        run_access(3'd1, 32'h1001, 0, 32'h0000C300, 0, 0);
        check("rr_after_rdata", rdata, 32'h000000C3);
        check("rr_after_stall", stall_cnt, 3);
        // bus timeout on the BUS_TIMEOUT=4 instance, data_ok never arrives
        @(negedge clk); mem_en = 1'b1; op = 3'd4; addr = 32'h1010; bus_rdata = 32'hCAFEF00D;
        t_cnt = 0; seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            #1;
            if (t_berr) seen = 1'b1;
            else begin
                t_cnt += int'(t_stall);
                addr_ok = t_req;
                @(negedge clk);
            end
        end
        addr_ok = 1'b0;
        check("to_seen", {31'b0, seen}, 1);
        check("to_stall_cycles", t_cnt, 6);
        check("to_rdata", t_rdata, 0);
        check("to_stall_done", {31'b0, t_stall}, 0);
        mem_en = 1'b0;
        @(negedge clk);
        #1 check("to_berr_clear", {31'b0, t_berr}, 0);
        check("to_idle_stall", {31'b0, t_stall}, 0);
        check("to_idle_req", {31'b0, t_req}, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter BUS_TIMEOUT, default 255: maximum cycles waiting for data_ok before bus_err_o is flagged.
REQ-002 SHALL have ports clk in 1 (system clock) and rst in 1 (asynchronous, active-low reset).
REQ-003 SHALL have ports mem_en_i in 1 (MEM-stage access valid) and mem_op_i in 3 (encoding: 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 SB, 6 SH, 7 SW).
REQ-004 SHALL have ports addr_i in 32 (aluoutM), wdata_i in 32 (writedataM) and flush_i in 1 (cancel current access).
REQ-005 SHALL have ports rdata_o out 32 (formatted load data, readdataM) and stall_o out 1 (hold the pipeline).
REQ-006 SHALL have ports adel_o out 1, ades_o out 1, badvaddr_o out 32 and bus_err_o out 1.
REQ-007 SHALL have bus request ports data_req_o out 1, data_wr_o out 1, data_size_o out 2 (0 byte, 1 half, 2 word) and data_addr_o out 32.
REQ-008 SHALL have bus data ports data_wdata_o out 32, data_addr_ok_i in 1, data_data_ok_i in 1 and data_rdata_i in 32.

Function
REQ-009 SHALL use a little-endian byte order with byte lane = addr_i[1:0].
REQ-010 SHALL flag misalignment combinationally: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0; a load sets adel_o, a store sets ades_o, badvaddr_o=addr_i, no bus request is issued and stall_o=0.
REQ-011 SHALL implement FSM IDLE->ADDR->DATA->DONE->IDLE.
REQ-012 SHALL transition IDLE->ADDR on a clock edge when mem_en_i=1, the address is legal and flush_i=0.
REQ-013 SHALL hold data_req_o=1 in ADDR, with addr/size/wr/wdata stable and registered from the IDLE cycle.
REQ-014 SHALL transition ADDR->DATA when data_addr_ok_i=1, and deassert data_req_o the following cycle.
REQ-015 SHALL transition DATA->DONE when data_data_ok_i=1, and register the formatted data_rdata_i into rdata_o.
REQ-016 SHALL deassert stall_o in DONE (the pipeline advances on that edge) and transition DONE->IDLE unconditionally.
REQ-017 SHALL drive stall_o = (IDLE & mem_en_i & legal) | ADDR | DATA.
REQ-018 SHALL format loads as: LB/LBU select byte lane and sign/zero-extend; LH/LHU select half addr[1] and sign/zero-extend; LW passes the word.
REQ-019 SHALL format stores as: SB replicates the byte 4x; SH replicates the half 2x; SW passes through.
REQ-020 SHALL count cycles in DATA with a counter; on reaching BUS_TIMEOUT it goes to DONE with bus_err_o=1 for the DONE cycle and rdata_o=0.
REQ-021 SHALL, on flush_i in ADDR before addr_ok, drop data_req_o next cycle and return to IDLE.
REQ-022 SHALL, on flush_i in ADDR coincident with addr_ok, or in DATA, set a discard flag, wait for data_ok, then return to IDLE without DONE and without updating rdata_o.
REQ-023 SHALL give flush_i priority over a new request in IDLE.
REQ-024 SHALL ignore data_data_ok_i outside DATA and data_addr_ok_i outside ADDR.

Reset
REQ-025 SHALL, on rst=0, asynchronously set state IDLE, counter 0, discard flag 0, and data_req_o, data_wr_o, stall_o, bus_err_o and adel_o/ades_o register sources to 0, with rdata_o=0 and data_addr_o=0.
REQ-026 SHALL NOT complete an access interrupted by reset mid-transfer; the first access after release starts from IDLE.

Structure
REQ-027 SHALL place the mem_op encodings, size encodings and the FSM state enum in shared package mem_pkg.
REQ-028 SHALL instantiate one combinational sub-module mem_align for load extraction, store replication and misalignment detection.

Verification
REQ-029 SHALL verify LB: addr 0x1003, bus rdata 0x80FF0000, addr_ok and data_ok one cycle each -> rdata_o=0xFFFFFF80, stall_o high exactly 3 cycles.
REQ-030 SHALL verify SH: addr 0x2002, wdata 0x1234ABCD -> data_wdata_o=0xABCDABCD, data_size_o=1, data_wr_o=1.
REQ-031 SHALL verify LW at addr 0x3001 -> adel_o=1, badvaddr_o=0x3001, data_req_o never asserted, stall_o=0.
REQ-032 SHALL verify flush_i pulsed in DATA, data_ok 4 cycles later -> returns to IDLE, rdata_o unchanged, no DONE cycle.
REQ-033 SHALL verify BUS_TIMEOUT=4 with data_ok never asserted -> bus_err_o=1 in the DONE cycle, then IDLE.
REQ-034 SHALL verify rst=0 asserted in ADDR -> data_req_o=0 and stall_o=0 immediately, state IDLE.
